// File: rtl/distortion_multi_pkg.sv
// distortion_pkg: shared types and constants for the multi-channel distortion stage
package distortion_pkg;
  typedef enum logic [1:0] {BYPASS, HARD, SOFT, RECT} mode_e;
  typedef enum logic [2:0] {IDLE, MUL, DIV, SHAPE, OUT} state_e;
  localparam int SOFT_SHIFT = 2;
endpackage

// File: rtl/distortion_multi_if.sv
// distortion_multi_if: frame in/out handshake bus (sample_in/in_valid/in_ready, gain/threshold/mode, sample_out/out_valid/out_ready)
interface distortion_multi_if
  import distortion_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int CHANNELS  = 2,
  parameter int GAIN_BITS = 7
);
  logic [CHANNELS*WIDTH-1:0] sample_in;
  logic                      in_valid;
  logic                      in_ready;
  logic [GAIN_BITS-1:0]      gain_num;
  logic [GAIN_BITS-1:0]      gain_den;
  logic [WIDTH-2:0]          threshold;
  mode_e                     mode;
  logic [CHANNELS*WIDTH-1:0] sample_out;
  logic                      out_valid;
  logic                      out_ready;
  modport master (
    output sample_in, in_valid, gain_num, gain_den, threshold, mode, out_ready,
    input  in_ready, sample_out, out_valid
  );
  modport slave (
    input  sample_in, in_valid, gain_num, gain_den, threshold, mode, out_ready,
    output in_ready, sample_out, out_valid
  );
endinterface

// File: rtl/distortion_multi_seq_divider.sv
// seq_divider: unsigned restoring divider, N cycles per division (start, dividend, divisor -> busy, done, quotient)
module seq_divider #(
  parameter int N = 23,
  parameter int D = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [D-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient
);
  localparam int CW = $clog2(N + 1);
  logic [CW-1:0] cnt;
  logic [D-1:0]  rem, dv;
  logic [D:0]    trial;
  logic          fit;
  assign trial = {rem, quotient[N-1]};
  assign fit   = trial >= {1'b0, dv};
  assign done  = busy && cnt == CW'(1);
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy     <= 1'b1;
      cnt      <= CW'(N);
      rem      <= '0;
      dv       <= divisor;
      quotient <= dividend;
    end else if (busy) begin
      busy     <= !done;
      cnt      <= cnt - CW'(1);
      rem      <= fit ? D'(trial - {1'b0, dv}) : trial[D-1:0];
      quotient <= {quotient[N-2:0], fit};
    end
  end
endmodule

// File: rtl/distortion_multi.sv
// distortion_multi: per-channel gain num/den then waveshaper (clk, reset, bus: slave side of distortion_multi_if)
module distortion_multi
  import distortion_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int CHANNELS  = 2,
  parameter int GAIN_BITS = 7
) (
  input logic               clk,
  input logic               reset,
  distortion_multi_if.slave bus
);
  localparam int P  = WIDTH + GAIN_BITS;
  localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  localparam logic [WIDTH-2:0] MAXV = '1;
  state_e                    state, next;
  logic [CHANNELS*WIDTH-1:0] x_q, res_q;
  logic [GAIN_BITS-1:0]      num_q, den_q;
  logic [WIDTH-2:0]          th_q;
  mode_e                     mode_q;
  logic [CW-1:0]             ch;
  logic                      neg, busy, done, last, acc;
  logic [P-1:0]              prod, quo;
  logic [WIDTH-1:0]          x_c, ax, soft_sum, shaped;
  logic [WIDTH-2:0]          m, hc, sc, mag_o;
  assign acc  = state == IDLE && bus.in_valid && bus.in_ready;
  assign last = ch == CW'(CHANNELS - 1);
  assign x_c  = x_q[ch*WIDTH +: WIDTH];
  assign ax   = x_c[WIDTH-1] ? -x_c : x_c;
  assign prod = P'(ax) * P'(num_q);
  seq_divider #(.N(P), .D(GAIN_BITS)) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (state == MUL),
    .dividend (prod),
    .divisor  (den_q == '0 ? GAIN_BITS'(1) : den_q),
    .busy     (busy),
    .done     (done),
    .quotient (quo)
  );
  // shaping works on a saturated magnitude, then reapplies the sign
  always_comb begin
    m        = |quo[P-1:WIDTH-1] ? MAXV : quo[WIDTH-2:0];
    hc       = m > th_q ? th_q : m;
    soft_sum = {1'b0, th_q} + WIDTH'((m - th_q) >> SOFT_SHIFT);
    sc       = th_q == '0 ? '0 : m <= th_q ? m : soft_sum > {1'b0, MAXV} ? MAXV : soft_sum[WIDTH-2:0];
    mag_o    = mode_q == SOFT ? sc : (mode_q == RECT && neg) ? '0 : hc;
    shaped   = mode_q == BYPASS ? x_c : neg ? -{1'b0, mag_o} : {1'b0, mag_o};
  end
  always_comb begin
    next = state;
    unique case (state)
      IDLE:    next = acc ? MUL : IDLE;
      MUL:     next = DIV;
      DIV:     next = done ? SHAPE : DIV;
      SHAPE:   next = busy ? SHAPE : last ? OUT : MUL;
      OUT:     next = (bus.out_valid && bus.out_ready) ? IDLE : OUT;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.in_ready   <= 1'b0;
      bus.out_valid  <= 1'b0;
      bus.sample_out <= '0;
      ch             <= '0;
    end else begin
      bus.in_ready <= next == IDLE;
      if (acc) ch <= '0;
      if (state == SHAPE && !busy) ch <= ch + CW'(1);
      // extra cycle in OUT registers the assembled frame onto the output
      if (state == OUT && !bus.out_valid) begin
        bus.out_valid  <= 1'b1;
        bus.sample_out <= res_q;
      end
      if (bus.out_valid && bus.out_ready) bus.out_valid <= 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (acc) begin
      x_q    <= bus.sample_in;
      num_q  <= bus.gain_num;
      den_q  <= bus.gain_den;
      th_q   <= bus.threshold;
      mode_q <= bus.mode;
    end
    if (state == MUL) neg <= x_c[WIDTH-1];
    if (state == SHAPE && !busy) res_q[ch*WIDTH +: WIDTH] <= shaped;
  end
endmodule

// File: tb/tb_distortion_multi.sv
// tb_distortion_multi: scoreboard bench for distortion_multi
module tb_distortion_multi;
  import distortion_pkg::*;
  logic clk, reset;
  int   total = 0, bad = 0, cyc = 0, acc = 0, hand = 0;
  int   sb_l[$], sb_r[$];
  bit   ov_q = 0;
  distortion_multi_if bus ();
  distortion_multi dut (.clk(clk), .reset(reset), .bus(bus));
  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int model(int x, int num, int den, int th, int md);
    int a, g, r;
    if (md == 0) return x;
    if (den == 0) den = 1;
    a = (x < 0 ? -x : x) * num / den;
    if (a > 32767) a = 32767;
    g = x < 0 ? -a : a;
    if (md == 3 && g < 0) g = 0;
    if (md == 2) begin
      if (th == 0) return 0;
      r = g < 0 ? -g : g;
      if (r > th) r = th + ((r - th) >> 2);
      if (r > 32767) r = 32767;
      return g < 0 ? -r : r;
    end
    return g > th ? th : (g < -th ? -th : g);
  endfunction

  task automatic send(input int l, r, num, den, th, md, el, er, input bit push);
    int n = 0;
    @(negedge clk);
    bus.sample_in = {16'(r), 16'(l)};
    bus.gain_num  = 7'(num);
    bus.gain_den  = 7'(den);
    bus.threshold = 15'(th);
    bus.mode      = mode_e'(2'(md));
    bus.in_valid  = 1'b1;
    if (push) begin
      sb_l.push_back(el);
      sb_r.push_back(er);
    end
    while (!bus.in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("accept_timeout", n, 0);
    else begin
      @(posedge clk);
      @(negedge clk);
      acc = cyc;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send_m(input int l, r, num, den, th, md);
    send(l, r, num, den, th, md, model(l, num, den, th, md), model(r, num, den, th, md), 1'b1);
  endtask

  initial forever begin
    @(negedge clk);
    #1;
    if (bus.out_valid && !ov_q) chk("latency", cyc - acc, 51);
    ov_q = bus.out_valid;
    if (bus.out_valid && bus.out_ready) begin
      if (sb_l.size() == 0) chk("unexpected_out", 1, 0);
      else begin
        chk("left", int'($signed(bus.sample_out[15:0])), sb_l.pop_front());
        chk("right", int'($signed(bus.sample_out[31:16])), sb_r.pop_front());
      end
      hand = cyc;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] first;
    bit s2_done, ov_seen;
    int n;
    reset = 1; bus.in_valid = 0; bus.out_ready = 1; bus.sample_in = '0;
    bus.gain_num = '0; bus.gain_den = '0; bus.threshold = '0; bus.mode = BYPASS;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_sample_out", int'(bus.sample_out), 0);
    chk("rst_in_ready", int'(bus.in_ready), 0);
    reset = 0;
    @(negedge clk);
    chk("post_rst_in_ready", int'(bus.in_ready), 1);
    send(10000, -10000, 4, 1, 24576, 1, 24576, -24576, 1);
    send(8000, 3000, 4, 1, 16384, 2, 20288, 12000, 1);
    send(-5000, 5000, 1, 1, 32767, 3, 0, 5000, 1);
    send(7, -7, 1, 2, 32767, 1, 3, -3, 1);
    send(1000, -1000, 3, 0, 32767, 1, 3000, -3000, 1);
    send(-32768, 123, 0, 5, 0, 0, -32768, 123, 1);
    send(-32768, 32767, 1, 1, 32767, 1, -32767, 32767, 1);
    send(500, -500, 1, 1, 0, 1, 0, 0, 1);
    send(500, -500, 1, 1, 0, 2, 0, 0, 1);
    send(500, -500, 1, 1, 0, 3, 0, 0, 1);
    for (int i = 0; i < 6; i++)
      send_m(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
             int'($urandom_range(0, 127)), int'($urandom_range(0, 127)),
             int'($urandom_range(0, 32767)), int'($urandom_range(0, 3)));
    n = 0;
    while (sb_l.size() != 0 && n < 300) begin @(negedge clk); n++; end
    chk("drain1", sb_l.size(), 0);
    bus.out_ready = 0;
    send(3000, -12000, 2, 1, 20000, 1, 6000, -20000, 1);
    n = 0;
    while (!bus.out_valid && n < 300) begin @(negedge clk); n++; end
    chk("bp_valid", int'(bus.out_valid), 1);
    first = bus.sample_out;
    s2_done = 0;
    fork
      begin
        send(5000, -1000, 1, 1, 1000, 2, 2000, -1000, 1);
        s2_done = 1;
      end
    join_none
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_stable", int'(bus.sample_out), int'(first));
      chk("bp_in_ready", int'(bus.in_ready), 0);
    end
    bus.out_ready = 1;
    n = 0;
    while (!s2_done && n < 300) begin @(negedge clk); n++; end
    chk("bp_second_done", int'(s2_done), 1);
    chk("bp_accept_gap", acc - hand, 2);
    n = 0;
    while (sb_l.size() != 0 && n < 300) begin @(negedge clk); n++; end
    chk("drain2", sb_l.size(), 0);
    send(1234, -4321, 2, 3, 30000, 1, 0, 0, 0);
    repeat (35) @(negedge clk);
    reset = 1;
    repeat (2) @(negedge clk);
    chk("midrst_in_ready", int'(bus.in_ready), 0);
    reset = 0;
    @(negedge clk);
    chk("midrst_release_in_ready", int'(bus.in_ready), 1);
    ov_seen = 0;
    repeat (60) begin
      @(negedge clk);
      ov_seen |= bus.out_valid;
    end
    chk("midrst_no_out", int'(ov_seen), 0);
    send(10000, -10000, 4, 1, 24576, 1, 24576, -24576, 1);
    n = 0;
    while (sb_l.size() != 0 && n < 300) begin @(negedge clk); n++; end
    chk("drain3", sb_l.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/distortion_multi.md
# distortion_multi

Parametrised, multi-mode successor to the combinational distortion stage: applies a rational gain (num/den), then a selectable waveshaper (hard clip, soft clip, half-wave rectify, or bypass) to a multi-channel sample frame. Sits in the effects chain between the codec receive path and downstream effects. Frames move in and out over a valid/ready handshake. One shared iterative divider processes channels serially, so per-frame latency is fixed.

## Interface
- `WIDTH`, 16: sample width, signed two's complement.
- `CHANNELS`, 2: channels per frame; channel 0 is left, channel 1 is right.
- `GAIN_BITS`, 7: width of the gain numerator and denominator.
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `sample_in` in CHANNELS*WIDTH: input frame; channel c occupies bits [c*WIDTH +: WIDTH].
- `in_valid` in 1: input frame is valid.
- `in_ready` out 1: block can accept a frame.
- `gain_num` in GAIN_BITS: gain numerator, unsigned.
- `gain_den` in GAIN_BITS: gain denominator, unsigned.
- `threshold` in WIDTH-1: clip threshold, unsigned magnitude.
- `mode` in 2: waveshaper select; 0 BYPASS, 1 HARD, 2 SOFT, 3 RECT.
- `sample_out` out CHANNELS*WIDTH: output frame, same packing as `sample_in`.
- `out_valid` out 1: output frame is valid.
- `out_ready` in 1: downstream accepts the output frame.

## Operation
- **Accept:** a frame is accepted when `in_valid && in_ready`. At accept, the block latches `sample_in`, `gain_num`, `gain_den`, `threshold` and `mode`. Later changes to these inputs do not affect the frame in flight.
- **FSM states:** IDLE → MUL → DIV → SHAPE → (next channel: MUL | last channel: OUT) → IDLE.
  - `in_ready` is high only in IDLE.
- **MUL (1 cycle):** computes |x|·num, width P = WIDTH+GAIN_BITS. The input sign is stored.
- **DIV (P cycles):** unsigned restoring division of the product by den. The quotient truncates toward zero and the sign is reapplied afterwards.
  - den = 0 is treated as den = 1.
  - num = 0 yields 0.
- **SHAPE (1 cycle):** first saturates the gained value g to ±(2^(WIDTH-1)−1). Then, by mode:
  - BYPASS: output is the latched input, with no gain applied.
  - HARD: clamp g to [−threshold, +threshold].
  - SOFT: if |g| > threshold, output is sign·(threshold + ((|g|−threshold) >> 2)), saturated to full scale. Otherwise output is g.
  - RECT: negative g becomes 0, then HARD clip is applied.
- **OUT:** `out_valid` is held high with `sample_out` stable until `out_ready`. On handoff the FSM returns to IDLE on the next cycle.
- **Boundaries:**
  - threshold = 0 in HARD, SOFT or RECT gives output 0.
  - Input −2^(WIDTH-1) with unity gain outputs −(2^(WIDTH-1)−1) in HARD when threshold is maximal.
  - A new input is never accepted while the frame in OUT is unconsumed.
- **Reset:** clears state to IDLE, `out_valid` = 0, `sample_out` = 0, `in_ready` = 0 during reset and 1 on the first cycle after reset. Reset asserted mid-frame discards the frame.

## Timing
- Latency L = CHANNELS·(P+2) + 1 cycles from the accept edge to `out_valid` high. L = 51 for the defaults.
- Throughput is at most one frame per L+1 cycles.
- Backpressure: `out_valid` stays high and `sample_out` is unchanged while `out_ready` = 0. `in_ready` stays 0 for this whole period.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Package `distortion_pkg`:
  - `mode_e` enum: BYPASS, HARD, SOFT, RECT.
  - `state_e` enum: IDLE, MUL, DIV, SHAPE, OUT.
  - Constant `SOFT_SHIFT` = 2.
- Sub-module `seq_divider`:
  - Parametrised unsigned restoring divider.
  - Ports: `start`, `dividend`, `divisor`, `busy`, `done`, `quotient`.
  - Takes exactly P cycles per division.

## Test plan
- HARD, gain 4/1, threshold 24576, L = 10000, R = −10000 → outputs 24576 and −24576; `out_valid` high exactly 51 cycles after accept.
- SOFT, gain 4/1, threshold 16384, L = 8000, R = 3000 → outputs 20288 and 12000.
- RECT, gain 1/1, threshold 32767, L = −5000, R = 5000 → outputs 0 and 5000. Gain 1/2 HARD with threshold max, inputs 7 and −7 → outputs 3 and −3.
- Gain 3/0 HARD, threshold max, input 1000 → output 3000. BYPASS with gain 0/5 and input −32768 → output −32768.
- `out_ready` held low for 10 cycles after `out_valid`: output is stable, `in_ready` = 0, and a second frame offered meanwhile is accepted only after handoff plus one cycle.
- `reset` pulsed during DIV of channel 1: `out_valid` never rises for that frame. After release, a new frame completes correctly with latency 51.
